fft_out_reorder_buf: RTL

- Sits directly downstream of the 128-point FFT core and upstream of the AXI slave read-data path.
- Captures each FFT output frame, which arrives in bit-reversed index order at one sample per valid cycle with no back-pressure.
- Replays each frame in natural order (bin 0..N-1) over a valid/ready stream.
- Ping-pong double buffer: one frame is filled while the previous one drains.

---
 rtl/fft_pkg.sv | 31 +++
 rtl/fft_reorder_bank_ram.sv | 28 ++
 rtl/fft_out_reorder_buf.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// Shared constants, FSM state types and the index bit-reversal helper for the
// FFT output reorder buffer.
package fft_pkg;

  localparam int FFT_N_PT   = 128;
  localparam int FFT_LOG2_N = 7;
  localparam int FFT_DW     = 32;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_DROP = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE   = 2'd0,
    R_FETCH  = 2'd1,
    R_STREAM = 2'd2
  } rd_state_e;

  // Reverse the low nbits of a (nbits <= 16); upper result bits are zero.
  function automatic logic [15:0] bitrev(input logic [15:0] a, input int nbits);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < nbits) r[nbits-1-i] = a[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_bank_ram.sv
// Simple dual-port frame store: one write port, one registered read port.
// Address is {bank, index}. The array has no reset; read data holds when re=0
// so a stalled consumer keeps seeing the prefetched word.
module fft_reorder_bank_ram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  // Write port and 1-cycle synchronous read port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fft_out_reorder_buf.sv
// FFT output reorder buffer: captures bit-reversed FFT frames into a ping-pong
// pair of banks and replays them in natural bin order on a valid/ready stream.
// A frame arriving while its target bank is still full is discarded whole.
// Optional: define FFT_REORDER_DROP_CNT_EN to add a saturating 16-bit drop_cnt.
module fft_out_reorder_buf
  import fft_pkg::*;
#(
  parameter int N_PT   = FFT_N_PT,
  parameter int LOG2_N = FFT_LOG2_N,
  parameter int DW     = FFT_DW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic              out_last,
  output logic [LOG2_N-1:0] out_index,
  output logic              frame_drop,
`ifdef FFT_REORDER_DROP_CNT_EN
  output logic [15:0]       drop_cnt,
`endif
  output logic              busy
);

  localparam logic [LOG2_N-1:0] IDX_LAST = LOG2_N'(N_PT - 1);
  localparam logic [LOG2_N-1:0] IDX_PEN  = LOG2_N'(N_PT - 2);

  // Write side state
  wr_state_e         wr_state_q, wr_state_d;
  logic [LOG2_N-1:0] wr_cnt_q, wr_cnt_d;
  logic              wr_bank_q, wr_bank_d;
  logic              frame_drop_q, frame_drop_d;
  logic              full_set;

  // Shared bank occupancy
  logic [1:0]        bank_full_q, bank_full_d;

  // Read side state
  rd_state_e         rd_state_q, rd_state_d;
  logic [LOG2_N-1:0] rd_cnt_q, rd_cnt_d;
  logic              rd_bank_q, rd_bank_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [LOG2_N-1:0] out_index_q, out_index_d;
  logic [DW-1:0]     out_data_q, out_data_d;
  logic              full_clr;

  // RAM ports
  logic              ram_we, ram_re;
  logic [LOG2_N:0]   ram_waddr, ram_raddr;
  logic [DW-1:0]     ram_rdata;
  logic [LOG2_N-1:0] wr_rev;

  // Samples of beat k land at bitrev(k), so bank address equals natural bin.
  assign wr_rev    = LOG2_N'(bitrev(16'(wr_cnt_q), LOG2_N));
  assign ram_waddr = {wr_bank_q, wr_rev};
  assign ram_raddr = {rd_bank_q, rd_cnt_q};

  fft_reorder_bank_ram #(
    .AW (LOG2_N + 1),
    .DW (DW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (in_data),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Write FSM: accept a whole frame into wr_bank, or swallow it if that bank is busy.
  always_comb begin
    wr_state_d   = wr_state_q;
    wr_cnt_d     = wr_cnt_q;
    wr_bank_d    = wr_bank_q;
    frame_drop_d = 1'b0;
    full_set     = 1'b0;
    ram_we       = 1'b0;
    unique case (wr_state_q)
      W_IDLE: begin
        if (in_valid) begin
          wr_cnt_d = LOG2_N'(1);
          // Registered flag: a bank freed this very cycle still counts as full.
          if (!bank_full_q[wr_bank_q]) begin
            ram_we     = 1'b1;
            wr_state_d = W_FILL;
          end else begin
            frame_drop_d = 1'b1;
            wr_state_d   = W_DROP;
          end
        end
      end
      W_FILL: begin
        if (in_valid) begin
          ram_we = 1'b1;
          if (wr_cnt_q == IDX_LAST) begin
            full_set   = 1'b1;
            wr_bank_d  = ~wr_bank_q;
            wr_cnt_d   = '0;
            wr_state_d = W_IDLE;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      W_DROP: begin
        if (in_valid) begin
          if (wr_cnt_q == IDX_LAST) begin
            wr_cnt_d   = '0;
            wr_state_d = W_IDLE;
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Read FSM: fetch bin 0, then keep one RAM word prefetched ahead of the output register.
  always_comb begin
    rd_state_d  = rd_state_q;
    rd_cnt_d    = rd_cnt_q;
    rd_bank_d   = rd_bank_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;
    full_clr    = 1'b0;
    ram_re      = 1'b0;
    unique case (rd_state_q)
      R_IDLE: begin
        if (bank_full_q[rd_bank_q]) begin
          ram_re     = 1'b1;            // rd_cnt_q is 0 here
          rd_cnt_d   = LOG2_N'(1);
          rd_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        out_valid_d = 1'b1;
        out_data_d  = ram_rdata;
        out_index_d = '0;
        out_last_d  = (N_PT == 1);
        ram_re      = 1'b1;             // prefetch bin 1
        rd_cnt_d    = rd_cnt_q + 1'b1;
        rd_state_d  = R_STREAM;
      end
      R_STREAM: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            full_clr    = 1'b1;
            rd_bank_d   = ~rd_bank_q;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            rd_cnt_d    = '0;
            rd_state_d  = R_IDLE;
          end else begin
            out_data_d  = ram_rdata;
            out_index_d = out_index_q + 1'b1;
            out_last_d  = (out_index_q == IDX_PEN);
            ram_re      = 1'b1;         // wrapped read after bin N-1 is harmless
            rd_cnt_d    = rd_cnt_q + 1'b1;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Bank flags: fill completion and drain completion always hit different banks.
  always_comb begin
    bank_full_d = bank_full_q;
    if (full_set) bank_full_d[wr_bank_q] = 1'b1;
    if (full_clr) bank_full_d[rd_bank_q] = 1'b0;
  end

  // Write side and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state_q   <= W_IDLE;
      wr_cnt_q     <= '0;
      wr_bank_q    <= 1'b0;
      frame_drop_q <= 1'b0;
      bank_full_q  <= '0;
    end else begin
      wr_state_q   <= wr_state_d;
      wr_cnt_q     <= wr_cnt_d;
      wr_bank_q    <= wr_bank_d;
      frame_drop_q <= frame_drop_d;
      bank_full_q  <= bank_full_d;
    end
  end

  // Read side and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_q  <= R_IDLE;
      rd_cnt_q    <= '0;
      rd_bank_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_index_q <= '0;
      out_data_q  <= '0;
    end else begin
      rd_state_q  <= rd_state_d;
      rd_cnt_q    <= rd_cnt_d;
      rd_bank_q   <= rd_bank_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
    end
  end

`ifdef FFT_REORDER_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of discarded frames.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (frame_drop_d && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign out_index  = out_index_q;
  assign frame_drop = frame_drop_q;
  assign busy       = (|bank_full_q) | (wr_state_q != W_IDLE);

endmodule
